// File: rtl/io_port_unit_pkg.sv
// ---------------------------------------------------------------------------
// io_port_unit_pkg
// Shared definitions for the memory-mapped I/O port unit. It holds the
// register index enumeration and the bit positions used in the STATUS and
// CTRL registers.
// ---------------------------------------------------------------------------
package io_port_unit_pkg;

    // Register index taken from addr[1:0] of an I/O access
    typedef enum logic [1:0] {
        IO_TXDATA = 2'd0,
        IO_RXDATA = 2'd1,
        IO_STATUS = 2'd2,
        IO_CTRL   = 2'd3
    } io_reg_t;

    // STATUS register bit positions
    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_FULL    = 2;
    localparam int ST_RX_EMPTY   = 3;
    localparam int ST_TX_OVF     = 4;
    localparam int ST_RX_UDF     = 5;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_RX_CNT_LSB = 12;
    localparam int ST_CNT_W      = 3;

    // CTRL register bit positions
    localparam int CTRL_RX_IE    = 0;
    localparam int CTRL_TX_IE    = 1;

endpackage

// File: rtl/io_fifo.sv
// ---------------------------------------------------------------------------
// io_fifo
// Small synchronous FIFO used for both the TX and RX paths of io_port_unit.
// A pop request on an empty FIFO is ignored; a push request on a full FIFO
// is accepted only when a pop happens in the same cycle (the freed slot is
// reused, so the count stays unchanged). The count therefore never exceeds
// DEPTH and the pointers simply wrap modulo DEPTH.
//
// Ports
//   clk, rst_n   clock and asynchronous active-low reset
//   push, din    push request and data
//   pop          pop request (head is presented on dout)
//   dout         head word, 0 when empty
//   full, empty  occupancy flags
//   count        number of stored words (0..DEPTH)
// ---------------------------------------------------------------------------
module io_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic          full_s;
    logic          empty_s;
    logic          do_pop_s;
    logic          do_push_s;
    logic [CW-1:0] count_next_s;

    // Occupancy flags and accepted push/pop decisions
    always_comb begin
        full_s    = (count_r == CW'(DEPTH));
        empty_s   = (count_r == {CW{1'b0}});
        do_pop_s  = pop & ~empty_s;
        // A pop in the same cycle frees the slot a full FIFO needs
        do_push_s = push & (~full_s | do_pop_s);
    end

    // Next occupancy count
    always_comb begin
        count_next_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointer and count state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
        end
    end

    // Storage array; contents are irrelevant while count is zero
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Head word, forced to zero when nothing is stored
    always_comb begin
        if (empty_s) begin
            dout = {DW{1'b0}};
        end else begin
            dout = mem_r[rd_ptr_r];
        end
    end

    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/io_port_unit.sv
// ---------------------------------------------------------------------------
// io_port_unit
// Memory-mapped I/O responder on the CPU data/IO bus. CPU writes to TXDATA
// are buffered in a TX FIFO drained by a peripheral over a valid/ready
// handshake; peripheral words are buffered in an RX FIFO read by the CPU
// through RXDATA. STATUS exposes FIFO state and two sticky error flags,
// CTRL holds interrupt enables, and irq_out is a registered interrupt.
//
// Register map (addr[1:0]): 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CTRL
//
// Ports
//   clk, rst_n          clock and asynchronous active-low reset
//   addr_in, wdata_in   access address and write data
//   wen_in              write enable, active-low
//   iom_in              one-cycle I/O access strobe
//   rdata_out           combinational read data (0 unless reading)
//   tx_valid/tx_data/tx_ready   TX head handshake towards the peripheral
//   rx_valid/rx_data/rx_ready   RX handshake from the peripheral
//   irq_out             registered interrupt request
// ---------------------------------------------------------------------------
module io_port_unit
    import io_port_unit_pkg::*;
#(
    parameter int            DW      = 16,
    parameter int            DEPTH   = 4,
    parameter logic [DW-1:0] IO_BASE = 16'hFF00
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] addr_in,
    input  logic [DW-1:0] wdata_in,
    input  logic          wen_in,
    input  logic          iom_in,
    output logic [DW-1:0] rdata_out,
    output logic          tx_valid,
    output logic [DW-1:0] tx_data,
    input  logic          tx_ready,
    input  logic          rx_valid,
    input  logic [DW-1:0] rx_data,
    output logic          rx_ready,
    output logic          irq_out
);

    localparam int CW = $clog2(DEPTH + 1);

    // Bus decode
    logic          sel_s;
    logic          wr_s;
    logic          rd_s;
    io_reg_t       idx_s;

    // FIFO interface
    logic          tx_push_s;
    logic          tx_pop_s;
    logic          tx_full_s;
    logic          tx_empty_s;
    logic [CW-1:0] tx_count_s;
    logic [DW-1:0] tx_head_s;
    logic          rx_push_s;
    logic          rx_pop_s;
    logic          rx_full_s;
    logic          rx_empty_s;
    logic [CW-1:0] rx_count_s;
    logic [DW-1:0] rx_head_s;

    // Registers
    logic          tx_ovf_r;
    logic          rx_udf_r;
    logic          rx_ie_r;
    logic          tx_ie_r;
    logic          irq_r;

    logic [DW-1:0] status_s;
    logic [DW-1:0] ctrl_s;
    logic          irq_next_s;

    // Address decode and access qualification
    always_comb begin
        sel_s = iom_in & (addr_in[DW-1:2] == IO_BASE[DW-1:2]);
        wr_s  = sel_s & ~wen_in;
        rd_s  = sel_s & wen_in;
        idx_s = io_reg_t'(addr_in[1:0]);
    end

    // FIFO handshakes
    always_comb begin
        tx_push_s = wr_s & (idx_s == IO_TXDATA);
        tx_pop_s  = ~tx_empty_s & tx_ready;
        rx_push_s = rx_valid & ~rx_full_s;
        rx_pop_s  = rd_s & (idx_s == IO_RXDATA);
    end

    io_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push_s),
        .pop   (tx_pop_s),
        .din   (wdata_in),
        .dout  (tx_head_s),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .count (tx_count_s)
    );

    io_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push_s),
        .pop   (rx_pop_s),
        .din   (rx_data),
        .dout  (rx_head_s),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .count (rx_count_s)
    );

    // STATUS and CTRL read images
    always_comb begin
        status_s                             = {DW{1'b0}};
        status_s[ST_TX_FULL]                 = tx_full_s;
        status_s[ST_TX_EMPTY]                = tx_empty_s;
        status_s[ST_RX_FULL]                 = rx_full_s;
        status_s[ST_RX_EMPTY]                = rx_empty_s;
        status_s[ST_TX_OVF]                  = tx_ovf_r;
        status_s[ST_RX_UDF]                  = rx_udf_r;
        status_s[ST_TX_CNT_LSB +: ST_CNT_W]  = ST_CNT_W'(tx_count_s);
        status_s[ST_RX_CNT_LSB +: ST_CNT_W]  = ST_CNT_W'(rx_count_s);
        ctrl_s                               = {DW{1'b0}};
        ctrl_s[CTRL_RX_IE]                   = rx_ie_r;
        ctrl_s[CTRL_TX_IE]                   = tx_ie_r;
    end

    // Read data mux; the RXDATA head is already 0 when the RX FIFO is empty
    always_comb begin
        rdata_out = {DW{1'b0}};
        if (rd_s) begin
            case (idx_s)
                IO_TXDATA: rdata_out = {DW{1'b0}};
                IO_RXDATA: rdata_out = rx_head_s;
                IO_STATUS: rdata_out = status_s;
                IO_CTRL:   rdata_out = ctrl_s;
                default:   rdata_out = {DW{1'b0}};
            endcase
        end else begin
            rdata_out = {DW{1'b0}};
        end
    end

    // Sticky error flags and interrupt enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ovf_r <= 1'b0;
            rx_udf_r <= 1'b0;
            rx_ie_r  <= 1'b0;
            tx_ie_r  <= 1'b0;
        end else begin
            // A TXDATA write is lost only if full with no peripheral pop this cycle
            if (tx_push_s && tx_full_s && !tx_pop_s) begin
                tx_ovf_r <= 1'b1;
            end else if (wr_s && (idx_s == IO_STATUS) && wdata_in[ST_TX_OVF]) begin
                tx_ovf_r <= 1'b0;
            end
            if (rx_pop_s && rx_empty_s) begin
                rx_udf_r <= 1'b1;
            end else if (wr_s && (idx_s == IO_STATUS) && wdata_in[ST_RX_UDF]) begin
                rx_udf_r <= 1'b0;
            end
            if (wr_s && (idx_s == IO_CTRL)) begin
                rx_ie_r <= wdata_in[CTRL_RX_IE];
                tx_ie_r <= wdata_in[CTRL_TX_IE];
            end
        end
    end

    // Interrupt source from pre-edge state, giving one cycle of latency
    always_comb begin
        irq_next_s = (rx_ie_r & ~rx_empty_s) | (tx_ie_r & tx_empty_s) | tx_ovf_r | rx_udf_r;
    end

    // Interrupt output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_next_s;
        end
    end

    assign tx_valid = ~tx_empty_s;
    assign tx_data  = tx_head_s;
    assign rx_ready = ~rx_full_s;
    assign irq_out  = irq_r;

endmodule

// File: tb/tb_io_port_unit.sv
// ---------------------------------------------------------------------------
// tb_io_port_unit
// Directed and randomized bench for io_port_unit. A queue-based reference
// model predicts every output each cycle; directed steps add explicit
// checks of the documented scenarios.
// ---------------------------------------------------------------------------
module tb_io_port_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic        wen_in;
    logic        iom_in;
    logic [15:0] rdata_out;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        rx_ready;
    logic        irq_out;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] tx_q[$];
    logic [15:0] rx_q[$];
    bit          m_ovf, m_udf, m_rxie, m_txie, m_irq;
    logic [15:0] last_rdata;

    io_port_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_in   (addr_in),
        .wdata_in  (wdata_in),
        .wen_in    (wen_in),
        .iom_in    (iom_in),
        .rdata_out (rdata_out),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .irq_out   (irq_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_status();
        logic [15:0] s;
        s = 16'd0;
        if (tx_q.size() == DEPTH) s = s + 16'd1;
        if (tx_q.size() == 0)     s = s + 16'd2;
        if (rx_q.size() == DEPTH) s = s + 16'd4;
        if (rx_q.size() == 0)     s = s + 16'd8;
        if (m_ovf)                s = s + 16'd16;
        if (m_udf)                s = s + 16'd32;
        s = s + 16'(tx_q.size()) * 16'd256;
        s = s + 16'(rx_q.size()) * 16'd4096;
        return s;
    endfunction

    task automatic model_clear();
        tx_q.delete();
        rx_q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_rxie = 1'b0; m_txie = 1'b0; m_irq = 1'b0;
    endtask

    // One bus cycle: inputs are already driven; check at negedge, then advance the model
    task automatic do_cycle();
        bit          sel, rd, wr, tx_pop, rx_push, new_irq;
        int          idx, txn, rxn;
        logic [15:0] exp_rd;
        @(negedge clk);
        sel = iom_in && (addr_in[15:2] == 14'h3FC0);
        rd  = sel && wen_in;
        wr  = sel && !wen_in;
        idx = int'(addr_in[1:0]);
        txn = tx_q.size();
        rxn = rx_q.size();
        exp_rd = 16'd0;
        if (rd) begin
            if (idx == 1 && rxn != 0) exp_rd = rx_q[0];
            if (idx == 2)             exp_rd = m_status();
            if (idx == 3)             exp_rd = {14'd0, m_txie, m_rxie};
        end
        chk("rdata",    rdata_out, exp_rd);
        chk("tx_valid", {15'd0, tx_valid}, {15'd0, txn != 0});
        chk("tx_data",  tx_data, (txn != 0) ? tx_q[0] : 16'd0);
        chk("rx_ready", {15'd0, rx_ready}, {15'd0, rxn < DEPTH});
        chk("irq",      {15'd0, irq_out}, {15'd0, m_irq});
        last_rdata = rdata_out;

        tx_pop  = (txn != 0) && tx_ready;
        rx_push = rx_valid && (rxn < DEPTH);
        new_irq = (m_rxie && rxn != 0) || (m_txie && txn == 0) || m_ovf || m_udf;
        if (tx_pop) void'(tx_q.pop_front());
        if (wr && idx == 0) begin
            if (txn < DEPTH || tx_pop) tx_q.push_back(wdata_in);
            else                       m_ovf = 1'b1;
        end
        if (rd && idx == 1) begin
            if (rxn != 0) void'(rx_q.pop_front());
            else          m_udf = 1'b1;
        end
        if (rx_push) rx_q.push_back(rx_data);
        if (wr && idx == 2) begin
            if (wdata_in[4]) m_ovf = 1'b0;
            if (wdata_in[5]) m_udf = 1'b0;
        end
        if (wr && idx == 3) begin
            m_rxie = wdata_in[0];
            m_txie = wdata_in[1];
        end
        m_irq = new_irq;
        @(posedge clk);
        #1;
    endtask

    task automatic io_wr(input logic [15:0] a, input logic [15:0] d);
        addr_in = a; wdata_in = d; wen_in = 1'b0; iom_in = 1'b1;
        do_cycle();
        iom_in = 1'b0; wen_in = 1'b1;
    endtask

    task automatic io_rd(input logic [15:0] a);
        addr_in = a; wen_in = 1'b1; iom_in = 1'b1;
        do_cycle();
        iom_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_valid"}, {15'd0, tx_valid}, 16'd0);
        chk({tag, "_tx_data"},  tx_data, 16'd0);
        chk({tag, "_rx_ready"}, {15'd0, rx_ready}, 16'd1);
        chk({tag, "_irq"},      {15'd0, irq_out}, 16'd0);
        chk({tag, "_rdata"},    rdata_out, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0; addr_in = 16'd0; wdata_in = 16'd0; wen_in = 1'b1; iom_in = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 16'd0; last_rdata = 16'd0;
        model_clear();
        #12;
        check_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Single TX write held by a stalled peripheral
        io_wr(16'hFF00, 16'h1234);
        chk("tx1_valid", {15'd0, tx_valid}, 16'd1);
        chk("tx1_data",  tx_data, 16'h1234);
        io_rd(16'hFF02);
        chk("tx1_count", {13'd0, last_rdata[10:8]}, 16'd1);
        tx_ready = 1'b1; idle(1); tx_ready = 1'b0;

        // Fill TX, overflow with a fifth word, then drain in order
        for (int i = 0; i < 5; i++) io_wr(16'hFF00, 16'h1001 + 16'(i));
        io_rd(16'hFF02);
        chk("tx_full_status", last_rdata, 16'h0419);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("tx_drain", tx_data, 16'h1001 + 16'(i));
            do_cycle();
        end
        tx_ready = 1'b0;
        chk("tx_drained", {15'd0, tx_valid}, 16'd0);
        io_wr(16'hFF02, 16'h0010);

        // Two RX words read back in order
        rx_valid = 1'b1; rx_data = 16'hA5A5; do_cycle();
        rx_data = 16'h5A5A; do_cycle();
        rx_valid = 1'b0;
        io_rd(16'hFF01); chk("rx_read1", last_rdata, 16'hA5A5);
        io_rd(16'hFF01); chk("rx_read2", last_rdata, 16'h5A5A);
        io_rd(16'hFF02); chk("rx_empty", {15'd0, last_rdata[3]}, 16'd1);

        // Underflow sets the sticky flag, a STATUS write clears it
        io_rd(16'hFF01); chk("udf_rdata", last_rdata, 16'd0);
        io_rd(16'hFF02); chk("udf_set", {15'd0, last_rdata[5]}, 16'd1);
        io_wr(16'hFF02, 16'h0020);
        io_rd(16'hFF02); chk("udf_clr", {15'd0, last_rdata[5]}, 16'd0);

        // RX interrupt timing
        io_wr(16'hFF03, 16'h0001);
        idle(2);
        chk("irq_idle", {15'd0, irq_out}, 16'd0);
        rx_valid = 1'b1; rx_data = 16'hBEEF; do_cycle(); rx_valid = 1'b0;
        chk("irq_push_edge", {15'd0, irq_out}, 16'd0);
        do_cycle();
        chk("irq_rise", {15'd0, irq_out}, 16'd1);
        io_rd(16'hFF01);
        chk("irq_pop_edge", {15'd0, irq_out}, 16'd1);
        do_cycle();
        chk("irq_fall", {15'd0, irq_out}, 16'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            iom_in   = ($urandom_range(0, 3) != 0);
            addr_in  = ($urandom_range(0, 4) != 0) ? (16'hFF00 | 16'($urandom_range(0, 3)))
                                                   : 16'($urandom());
            wen_in   = 1'($urandom_range(0, 1));
            wdata_in = 16'($urandom());
            tx_ready = ($urandom_range(0, 2) == 0);
            rx_valid = ($urandom_range(0, 1) == 0);
            rx_data  = 16'($urandom());
            do_cycle();
        end
        iom_in = 1'b0; wen_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0;

        // Reset with both FIFOs partially filled
        io_wr(16'hFF03, 16'h0000);
        while (tx_q.size() != 0 || rx_q.size() != 0) begin
            tx_ready = 1'b1; addr_in = 16'hFF01; wen_in = 1'b1; iom_in = 1'b1;
            do_cycle();
        end
        tx_ready = 1'b0; iom_in = 1'b0;
        io_wr(16'hFF00, 16'h0BAD);
        io_wr(16'hFF00, 16'h0C0D);
        rx_valid = 1'b1; rx_data = 16'h7777; do_cycle();
        rx_valid = 1'b0;
        chk("pre_rst_tx", {15'd0, tx_valid}, 16'd1);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("midrst");
        model_clear();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        io_rd(16'hFF02);
        chk("rst_status", last_rdata, 16'h000A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
